// File: rtl/cpu_pkg.sv
// Types shared by the PC, instruction memory, fetch and decode blocks.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] instr_t;

  typedef struct packed {
    addr_t  addr;
    instr_t data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {addr, data} fetch entries with synchronous clear.
// The head entry is read combinationally so decode sees it in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  output fetch_entry_t       head_entry,
  output logic [PTR_W:0]     count
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left uncleared; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !rst && !clr) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between the PC stage and decode: issues reads to the synchronous
// instruction memory and queues returned words, reserving a slot per read in flight.
module instr_fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic              ins_ready,
  output logic [PTR_W:0]    occupancy
);

  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W + 2)'(DEPTH);

  logic           inflight_q, inflight_d;
  addr_t          req_addr_q, req_addr_d;
  logic [PTR_W:0] count;
  logic [PTR_W+1:0] reserved;
  logic           acc, push, pop, have_head;
  fetch_entry_t   head_entry, push_entry;

  // Readiness depends only on registered state, never on ins_ready.
  always_comb begin
    reserved   = {1'b0, count} + {{(PTR_W + 1){1'b0}}, inflight_q};
    pc_ready   = ~rst & ~flush & (reserved < DEPTH_L);
    acc        = pc_valid & pc_ready;
    imem_en    = acc;
    imem_addr  = pc_addr;
    inflight_d = acc;
    req_addr_d = acc ? pc_addr : req_addr_q;
  end

  always_comb begin
    have_head  = (count != '0);
    push       = inflight_q & ~flush;
    pop        = have_head & ins_ready & ~flush;
    push_entry = '{addr: req_addr_q, data: imem_rdata};
    ins_valid  = have_head & ~rst;
    ins_data   = rst ? '0 : head_entry.data;
    ins_addr   = rst ? '0 : head_entry.addr;
    occupancy  = rst ? '0 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
    req_addr_q <= req_addr_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule
